// File: rtl/group4_led_ctrl.sv
// Avalon-MM LED output controller: R/W data and blink mask, atomic set/clear/toggle,
// and a programmable-divider blink engine gating the blink-enabled bits.
`timescale 1ns/1ps
module group4_led_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int unsigned DIV_W        = 24,
    parameter logic [31:0] PERIOD_RESET = 32'd2499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE = 3'd6;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic [WIDTH-1:0] r_out;

    logic             w_wr;
    logic             w_term;
    logic [WIDTH-1:0] w_wdat;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] w_blink_nxt;
    logic [DIV_W-1:0] w_period_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_phase_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_term   = (r_cnt == r_period);
    assign w_wdat   = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;

    // Next-state: blink engine free-runs; a PERIOD write restarts the count but never blocks a phase flip.
    always_comb begin
        w_data_nxt   = r_data;
        w_blink_nxt  = r_blink;
        w_period_nxt = r_period;
        w_cnt_nxt    = w_term ? '0 : r_cnt + DIV_W'(1);
        w_phase_nxt  = r_phase ^ w_term;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_data_nxt = w_wdat;
                ADDR_BLINK:  w_blink_nxt = w_wdat;
                ADDR_PERIOD: begin
                    w_period_nxt = writedata[DIV_W-1:0];
                    w_cnt_nxt    = '0;
                end
                ADDR_SET:    w_data_nxt = r_data | w_wdat;
                ADDR_CLEAR:  w_data_nxt = r_data & ~w_wdat;
                ADDR_TOGGLE: w_data_nxt = r_data ^ w_wdat;
                default:     ;
            endcase
        end
        w_out_nxt = w_data_nxt & ~(w_blink_nxt & {WIDTH{~w_phase_nxt}});
    end

    // The LED drive is registered from next-state values so it changes on the same edge as DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= WIDTH'(RESET_VALUE);
            r_blink  <= '0;
            r_period <= DIV_W'(PERIOD_RESET);
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_out    <= WIDTH'(RESET_VALUE);
        end else begin
            r_data   <= w_data_nxt;
            r_blink  <= w_blink_nxt;
            r_period <= w_period_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_out    <= w_out_nxt;
        end
    end

    assign out_port = r_out;

    // Zero-latency read mux; chipselect is deliberately not decoded.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(r_data);
            ADDR_BLINK:  readdata = 32'(r_blink);
            ADDR_PERIOD: readdata = 32'(r_period);
            ADDR_STATUS: readdata = 32'(r_phase);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_group4_led_ctrl.sv
// Bench for group4_led_ctrl: directed vectors with literal expectations plus a
// cycle-by-cycle reference model of the 8-bit build; a 4-bit build checks truncation.
`timescale 1ns/1ps
module tb_group4_led_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [31:0] readdata4;
    logic [3:0]  out_port4;

    int checks   = 0;
    int failures = 0;

    group4_led_ctrl #(.WIDTH(8), .RESET_VALUE(32'hA5), .DIV_W(24), .PERIOD_RESET(32'd5)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
        .writedata(wd), .readdata(readdata), .out_port(out_port));

    group4_led_ctrl #(.WIDTH(4), .RESET_VALUE(32'hA), .DIV_W(8), .PERIOD_RESET(32'd5)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
        .writedata(wd), .readdata(readdata4), .out_port(out_port4));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase = base ^ (number of completed PERIOD+1 windows since the last count restart).
    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    logic [23:0] m_per;
    longint      m_n;
    logic        m_base;
    logic        m_phase;
    logic        m_term;
    logic [7:0]  m_out;
    logic [31:0] m_rd;

    assign m_phase = m_base ^ (((m_n / (longint'(m_per) + 1)) % 2) == 1);
    assign m_term  = ((m_n % (longint'(m_per) + 1)) == longint'(m_per));
    assign m_out   = m_data & ~(m_blink & {8{~m_phase}});

    always_comb begin
        m_rd = 32'h0;
        case (address)
            3'd0: m_rd = 32'(m_data);
            3'd1: m_rd = 32'(m_blink);
            3'd2: m_rd = 32'(m_per);
            3'd3: m_rd = 32'(m_phase);
            default: m_rd = 32'h0;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  <= 8'hA5;
            m_blink <= 8'h00;
            m_per   <= 24'd5;
            m_n     <= 0;
            m_base  <= 1'b0;
        end else begin
            if (cs && !wn && address == 3'd2) begin
                m_base <= m_phase ^ m_term;
                m_n    <= 0;
                m_per  <= wd[23:0];
            end else begin
                m_n <= m_n + 1;
            end
            if (cs && !wn) begin
                case (address)
                    3'd0: m_data  <= wd[7:0];
                    3'd1: m_blink <= wd[7:0];
                    3'd4: m_data  <= m_data | wd[7:0];
                    3'd5: m_data  <= m_data & ~wd[7:0];
                    3'd6: m_data  <= m_data ^ wd[7:0];
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_out", 32'(out_port), 32'(m_out));
        chk("model_rd", readdata, m_rd);
    end

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; address = a; wd = d;
    endtask

    task automatic drive_idle(input logic [2:0] a);
        cs = 1'b0; wn = 1'b1; address = a; wd = 32'h0;
    endtask

    task automatic edge_out(input string nm, input logic [7:0] exp);
        @(posedge clk); #1;
        chk(nm, 32'(out_port), 32'(exp));
        @(negedge clk);
    endtask

    task automatic edge_rd(input string nm, input logic [31:0] exp);
        @(posedge clk); #1;
        chk(nm, readdata, exp);
        @(negedge clk);
    endtask

    task automatic read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        drive_idle(a); #1;
        chk(nm, readdata, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle(3'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0;
        cs = 1'b0; wn = 1'b1; address = 3'd0; wd = 32'h0;

        // Reset values
        do_reset();
        chk("rst_out", 32'(out_port), 32'hA5);
        chk("rst_out4", 32'(out_port4), 32'hA);
        read_chk("rst_data", 3'd0, 32'hA5);
        read_chk("rst_blink", 3'd1, 32'h0);
        read_chk("rst_period", 3'd2, 32'd5);
        read_chk("rst_status", 3'd3, 32'h0);

        // Data and atomic writes
        drive_wr(3'd0, 32'h0F); edge_out("wr_data_out", 8'h0F); read_chk("wr_data_rd", 3'd0, 32'h0F);
        drive_wr(3'd4, 32'h30); edge_out("set_out", 8'h3F);     read_chk("set_rd", 3'd0, 32'h3F);
        drive_wr(3'd5, 32'h03); edge_out("clr_out", 8'h3C);     read_chk("clr_rd", 3'd0, 32'h3C);
        drive_wr(3'd6, 32'h81); edge_out("tgl_out", 8'hBD);     read_chk("tgl_rd", 3'd0, 32'hBD);
        drive_wr(3'd3, 32'hFFFF_FFFF); edge_out("status_wr_out", 8'hBD);
        drive_wr(3'd7, 32'hFF);        edge_out("addr7_wr_out", 8'hBD);
        read_chk("addr7_data_rd", 3'd0, 32'hBD);
        for (int a = 4; a < 8; a++) read_chk("hi_addr_rd", 3'(a), 32'h0);

        // Blink with PERIOD=3 from a fresh reset; edge k counts from release
        do_reset();
        drive_wr(3'd0, 32'hFF); edge_out("blk_e1", 8'hFF);
        drive_wr(3'd1, 32'hF0); edge_out("blk_e2", 8'h0F);
        drive_wr(3'd2, 32'd3);  edge_out("blk_e3", 8'h0F);
        drive_idle(3'd3);
        for (int k = 4; k <= 14; k++) begin
            @(posedge clk); #1;
            chk("blk_p3_out", 32'(out_port), (((k - 3) / 4) % 2 == 1) ? 32'hFF : 32'h0F);
            chk("blk_p3_status", readdata, 32'(((k - 3) / 4) % 2));
            @(negedge clk);
        end

        // PERIOD=0 lands on a terminal count; then PERIOD=9 written at terminal
        drive_wr(3'd2, 32'd0); edge_out("p0_e15", 8'hFF);
        drive_idle(3'd3);
        edge_out("p0_e16", 8'h0F);
        edge_out("p0_e17", 8'hFF);
        drive_wr(3'd2, 32'd9); edge_out("p9_e18", 8'h0F);
        drive_idle(3'd3);
        for (int k = 19; k <= 29; k++)
            edge_rd("p9_status", (k >= 28) ? 32'd1 : 32'd0);

        // Asynchronous reset between edges while blinking
        @(posedge clk); #3;
        reset_n = 1'b0; #1;
        chk("async_rst_out", 32'(out_port), 32'hA5);
        chk("async_rst_out4", 32'(out_port4), 32'hA);
        chk("async_rst_status", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++)
            edge_rd("post_rst_status", (k >= 6) ? 32'd1 : 32'd0);

        // Narrow build: truncation, ignored address 7, zero high reads
        drive_wr(3'd0, 32'hFFFF_FFFF); edge_out("w4_wide_out8", 8'hFF);
        drive_idle(3'd0); #1;
        chk("w4_data_rd", readdata4, 32'h0000_000F);
        chk("w4_out", 32'(out_port4), 32'hF);
        drive_wr(3'd7, 32'h0); edge_out("w4_addr7_out8", 8'hFF);
        drive_idle(3'd0); #1;
        chk("w4_addr7_rd", readdata4, 32'h0000_000F);
        chk("w4_addr7_out", 32'(out_port4), 32'hF);
        for (int a = 4; a < 8; a++) begin
            drive_idle(3'(a)); #1;
            chk("w4_hi_addr_rd", readdata4, 32'h0);
        end

        @(posedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
